// File: rtl/key_pkg.sv
// Shared types and constants for the key event detector.
// Optional auto-repeat is enabled by defining KEY_REPEAT_EN.
package key_pkg;

  typedef enum logic [2:0] {
    KS_IDLE,
    KS_PRESS1,
    KS_WAIT2,
    KS_PRESS2,
    KS_LONG
  } key_state_t;

  localparam int TICKS_PER_MS_DIV = 1000;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_event_detector_if.sv
// Key level in, classified event pulses out.
// master drives the key level, slave produces the events.
interface key_event_detector_if;

  logic key_n;
  logic pressed;
  logic evt_short;
  logic evt_double;
  logic evt_long;
  logic evt_repeat;

  modport master (
    output key_n,
    input  pressed,
    input  evt_short,
    input  evt_double,
    input  evt_long,
    input  evt_repeat
  );

  modport slave (
    input  key_n,
    output pressed,
    output evt_short,
    output evt_double,
    output evt_long,
    output evt_repeat
  );

endinterface

// File: rtl/key_event_detector_ms_tick_gen.sv
// Free-running 1 ms tick enable: one cycle high every
// F_CLK/1000 clocks, at the counter's terminal value.
module ms_tick_gen
  import key_pkg::*;
#(
  parameter int F_CLK = 50000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int TPM = F_CLK / TICKS_PER_MS_DIV;
  localparam int CW  = (TPM > 1) ? $clog2(TPM) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TPM - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (cnt_q == CNT_MAX) cnt_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign o_tick = (cnt_q == CNT_MAX);

endmodule

// File: rtl/key_event_detector.sv
// Debounced key -> short / double / long / repeat pulses.
// Auto-repeat in LONG only when KEY_REPEAT_EN is defined.
module key_event_detector
  import key_pkg::*;
#(
  parameter int F_CLK     = 50000000,
  parameter int LONG_MS   = 800,
  parameter int DOUBLE_MS = 250,
  parameter int REPEAT_MS = 100
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_pressed,
  output logic o_short,
  output logic o_double,
  output logic o_long,
  output logic o_repeat
);

  localparam int MS_MAX = max3(LONG_MS, DOUBLE_MS, REPEAT_MS);
  localparam int MW     = $clog2(MS_MAX + 1);
  localparam logic [MW-1:0] LONG_END = MW'(LONG_MS - 1);
  localparam logic [MW-1:0] DBL_END  = MW'(DOUBLE_MS - 1);
  localparam logic [MW-1:0] MS_SAT   = '1;
`ifdef KEY_REPEAT_EN
  localparam logic [MW-1:0] REP_END  = MW'(REPEAT_MS - 1);
`endif

  logic       tick;
  logic       key_q, key_d;
  logic       arm_q, arm_d;
  logic       prs_e, rel_e;
  key_state_t state_q, state_d;
  logic [MW-1:0] ms_q, ms_d;
  logic       ms_clr;
  logic       pressed_q, pressed_d;
  logic       short_q, short_d;
  logic       double_q, double_d;
  logic       long_q, long_d;
  logic       rep_q, rep_d;

  ms_tick_gen #(
    .F_CLK (F_CLK)
  ) u_tick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_tick  (tick)
  );

  // arm_q: key seen released since reset, so a key
  // held through reset never counts as a press
  assign key_d = i_key_n;
  assign arm_d = arm_q | i_key_n;
  assign prs_e = arm_q & key_q & ~i_key_n;
  assign rel_e = ~key_q & i_key_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= KS_IDLE;
      key_q     <= 1'b1;
      arm_q     <= 1'b0;
      ms_q      <= '0;
      pressed_q <= 1'b0;
      short_q   <= 1'b0;
      double_q  <= 1'b0;
      long_q    <= 1'b0;
      rep_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      arm_q     <= arm_d;
      ms_q      <= ms_d;
      pressed_q <= pressed_d;
      short_q   <= short_d;
      double_q  <= double_d;
      long_q    <= long_d;
      rep_q     <= rep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      KS_IDLE:
        if (prs_e) state_d = KS_PRESS1;
      KS_PRESS1:
        if (rel_e)
          state_d = KS_WAIT2;
        else if (tick && ms_q == LONG_END)
          state_d = KS_LONG;
      KS_WAIT2:
        if (prs_e)
          state_d = KS_PRESS2;
        else if (tick && ms_q == DBL_END)
          state_d = KS_IDLE;
      KS_PRESS2:
        if (rel_e) state_d = KS_IDLE;
      KS_LONG:
        if (rel_e) state_d = KS_IDLE;
      default:
        state_d = KS_IDLE;
    endcase
  end

  always_comb begin
    pressed_d = ~i_key_n;
    short_d   = (state_q == KS_WAIT2) & ~prs_e
              & tick & (ms_q == DBL_END);
    double_d  = (state_q == KS_PRESS2) & rel_e;
    long_d    = (state_q == KS_PRESS1) & ~rel_e
              & tick & (ms_q == LONG_END);
    rep_d     = 1'b0;
    ms_clr    = 1'b0;
`ifdef KEY_REPEAT_EN
    if ((state_q == KS_LONG) && !rel_e && tick
        && (ms_q == REP_END)) begin
      rep_d  = 1'b1;
      ms_clr = 1'b1;
    end
`endif
  end

  always_comb begin
    ms_d = ms_q;
    if (state_d != state_q || ms_clr)
      ms_d = '0;
    else if (tick && ms_q != MS_SAT)
      ms_d = ms_q + MW'(1);
  end

  assign o_pressed = pressed_q;
  assign o_short   = short_q;
  assign o_double  = double_q;
  assign o_long    = long_q;
  assign o_repeat  = rep_q;

endmodule
